// File: rtl/yarvi_sim_pkg.sv
// yarvi_sim harness shared types and constants.
// Optional echo build: define YARVI_SIM_ECHO_EN.
package yarvi_sim_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_EXIT,
    S_DONE
  } state_t;

  localparam logic [7:0] END_BYTE_DEF = 8'h04;
  localparam logic [7:0] PASS_CODE    = 8'h00;

endpackage

// File: rtl/yarvi_sim_fifo.sv
// Synchronous byte FIFO, power-of-2 depth.
// Registered full/empty flags; pushes while full are dropped.
module yarvi_sim_fifo
  import yarvi_sim_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    count_nxt = count_nxt + (AW+1)'(do_push);
    count_nxt = count_nxt - (AW+1)'(do_pop);
  end

  // storage array, no reset needed
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers, count and flags
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_C);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/yarvi_sim_harness.sv
// Sim harness for yarvi_soc: reset stretch, paced stimulus,
// exit decode, cycle timeout. Echo build: YARVI_SIM_ECHO_EN.
module yarvi_sim_harness
  import yarvi_sim_pkg::*;
#(
  parameter int         RESET_CYCLES   = 1,
  parameter int         TIMEOUT_CYCLES = 1600,
  parameter int         CNT_W          = 32,
  parameter int         STIM_DEPTH     = 16,
  parameter int         GAP_CYCLES     = 0,
  parameter logic [7:0] END_BYTE       = END_BYTE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  output logic             soc_reset,
  input  logic             stim_we,
  input  logic [7:0]       stim_data,
  output logic             stim_full,
  output logic             soc_in_valid,
  input  logic             soc_in_ready,
  output logic [7:0]       soc_in_data,
  input  logic             soc_out_valid,
  output logic             soc_out_ready,
  input  logic [7:0]       soc_out_data,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [7:0]       exit_code,
  output logic [CNT_W-1:0] cycles,
  output logic [15:0]      out_count
);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      rst_cnt;
  logic [15:0]      gap_cnt;
  logic [CNT_W-1:0] cycles_nxt;
  logic [7:0]       fifo_rdata;
  logic             fifo_empty;
  logic             run;
  logic             acc;
  logic             exit_acc;
  logic             tmo;
  logic             rst_done;
  logic             launch;
  logic             in_acc;

  assign run      = (state == S_RUN) || (state == S_EXIT);
  assign acc      = soc_out_valid && soc_out_ready && run;
  assign exit_acc = acc && (state == S_EXIT);
  assign tmo      = run && !exit_acc &&
                    (cycles == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rst_done = (state == S_RESET) &&
                    (rst_cnt == 32'(RESET_CYCLES - 1));
  assign launch   = run && !soc_in_valid && !fifo_empty &&
                    (gap_cnt == '0);
  assign in_acc   = soc_in_valid && soc_in_ready;

  yarvi_sim_fifo #(
    .DEPTH(STIM_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (stim_we),
    .wdata(stim_data),
    .pop  (launch),
    .rdata(fifo_rdata),
    .full (stim_full),
    .empty(fifo_empty)
  );

  // run-cycle counter, saturating at all-ones
  always_comb begin
    cycles_nxt = cycles;
    if (run && (cycles != '1)) cycles_nxt = cycles + 1'b1;
  end

  // next-state decode; an exit byte on the timeout cycle wins
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: if (rst_done) state_nxt = S_RUN;
      S_RUN: begin
        if (tmo)
          state_nxt = S_DONE;
        else if (acc && (soc_out_data == END_BYTE))
          state_nxt = S_EXIT;
      end
      S_EXIT: if (exit_acc || tmo) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_RESET;
    else       state <= state_nxt;
  end

  // registered outputs, counters and stimulus pacing
  always_ff @(posedge clock) begin
    if (reset) begin
      soc_reset     <= 1'b1;
      soc_out_ready <= 1'b0;
      soc_in_valid  <= 1'b0;
      soc_in_data   <= '0;
      rst_cnt       <= '0;
      gap_cnt       <= '0;
      cycles        <= '0;
      out_count     <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timed_out     <= 1'b0;
      exit_code     <= '0;
    end else begin
      soc_reset     <= (state_nxt == S_RESET);
      soc_out_ready <= (state_nxt == S_RUN) ||
                       (state_nxt == S_EXIT);
      if ((state == S_RESET) && !rst_done)
        rst_cnt <= rst_cnt + 32'd1;
      cycles <= cycles_nxt;
      if (acc && (out_count != 16'hFFFF))
        out_count <= out_count + 16'd1;
      if (exit_acc) begin
        exit_code <= soc_out_data;
        pass      <= (soc_out_data == PASS_CODE);
        done      <= 1'b1;
      end else if (tmo) begin
        timed_out <= 1'b1;
        pass      <= 1'b0;
        done      <= 1'b1;
      end
      if (in_acc) begin
        soc_in_valid <= 1'b0;
        gap_cnt      <= 16'(GAP_CYCLES);
      end else begin
        if (gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
        if (launch) begin
          soc_in_valid <= 1'b1;
          soc_in_data  <= fifo_rdata;
        end
      end
    end
  end

`ifdef YARVI_SIM_ECHO_EN
  // console echo of SoC output and final verdict
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (acc && (state == S_RUN) && (soc_out_data != END_BYTE))
        $write("%c", soc_out_data);
      if (exit_acc) begin
        if (soc_out_data == PASS_CODE) $display("PASS");
        else $display("FAIL %0d", soc_out_data);
      end else if (tmo) begin
        $display("TIMED OUT %0d", cycles_nxt);
      end
    end
  end
`else
  // silent build: no console output
`endif

endmodule

// File: tb/tb_yarvi_sim_harness.sv
// Bench for yarvi_sim_harness: scoreboarded stimulus stream
// and result queue, directed SoC output sequences.
module tb_yarvi_sim_harness;

  localparam int RC   = 4;
  localparam int TO   = 100;
  localparam int GAP  = 2;
  localparam int DEP  = 16;

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [7:0]  code;
    logic [15:0] oc;
    logic        chk;
    logic [31:0] cyc;
  } res_t;

  logic        clock;
  logic        reset;
  logic        soc_reset;
  logic        stim_we;
  logic [7:0]  stim_data;
  logic        stim_full;
  logic        soc_in_valid;
  logic        soc_in_ready;
  logic [7:0]  soc_in_data;
  logic        soc_out_valid;
  logic        soc_out_ready;
  logic [7:0]  soc_out_data;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic [7:0]  exit_code;
  logic [31:0] cycles;
  logic [15:0] out_count;

  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];
  res_t res_q[$];

  yarvi_sim_harness #(
    .RESET_CYCLES  (RC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (32),
    .STIM_DEPTH    (DEP),
    .GAP_CYCLES    (GAP),
    .END_BYTE      (8'h04)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .soc_reset    (soc_reset),
    .stim_we      (stim_we),
    .stim_data    (stim_data),
    .stim_full    (stim_full),
    .soc_in_valid (soc_in_valid),
    .soc_in_ready (soc_in_ready),
    .soc_in_data  (soc_in_data),
    .soc_out_valid(soc_out_valid),
    .soc_out_ready(soc_out_ready),
    .soc_out_data (soc_out_data),
    .done         (done),
    .pass         (pass),
    .timed_out    (timed_out),
    .exit_code    (exit_code),
    .cycles       (cycles),
    .out_count    (out_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: stimulus stream and end-of-test results
  initial begin : monitor
    logic       prev_stall;
    logic       prev_valid;
    logic [7:0] prev_data;
    logic       prev_done;
    logic       seen_acc;
    int         idle;
    res_t       r;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    prev_data  = '0;
    prev_done  = 1'b0;
    seen_acc   = 1'b0;
    idle       = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset || soc_reset) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        seen_acc   = 1'b0;
        idle       = 0;
      end else begin
        if (soc_in_valid && prev_stall)
          check("in_stable", 32'(soc_in_data), 32'(prev_data));
        if (soc_in_valid && !prev_valid && seen_acc)
          check("gap_idle", 32'(idle >= GAP), 32'd1);
        if (!soc_in_valid) idle++;
        if (soc_in_valid && soc_in_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL in_extra: got %0h expected none",
                     soc_in_data);
          end else begin
            check("in_order", 32'(soc_in_data),
                  32'(exp_q.pop_front()));
          end
          seen_acc = 1'b1;
          idle     = 0;
        end
        prev_stall = soc_in_valid && !soc_in_ready;
        prev_valid = soc_in_valid;
        prev_data  = soc_in_data;
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_extra: got done=1 expected none");
        end else begin
          r = res_q.pop_front();
          check("res_pass", 32'(pass), 32'(r.pass));
          check("res_tmo", 32'(timed_out), 32'(r.tmo));
          check("res_code", 32'(exit_code), 32'(r.code));
          check("res_outcnt", 32'(out_count), 32'(r.oc));
          if (r.chk) check("res_cycles", cycles, r.cyc);
        end
      end
      prev_done = done;
    end
  end

  // drive one SoC output byte; returns on the negedge after accept
  task automatic send_out(input logic [7:0] b);
    int n;
    n = 0;
    soc_out_valid = 1'b1;
    soc_out_data  = b;
    #1;
    while (!soc_out_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL out_accept: got no ready expected ready");
    end
    @(negedge clock);
    soc_out_valid = 1'b0;
  endtask

  // reset for three cycles, release, wait for RUN
  task automatic restart();
    int n;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_soc_reset", 32'(soc_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    n = 0;
    while (!soc_out_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("run_entry", 32'(soc_out_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    reset         = 1'b1;
    stim_we       = 1'b0;
    stim_data     = '0;
    soc_in_ready  = 1'b0;
    soc_out_valid = 1'b0;
    soc_out_data  = '0;

    // reset values, then overflow, stall, pacing and timeout
    repeat (3) @(negedge clock);
    check("r_soc_reset", 32'(soc_reset), 32'd1);
    check("r_in_valid", 32'(soc_in_valid), 32'd0);
    check("r_in_data", 32'(soc_in_data), 32'd0);
    check("r_out_ready", 32'(soc_out_ready), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_pass", 32'(pass), 32'd0);
    check("r_timed_out", 32'(timed_out), 32'd0);
    check("r_exit_code", 32'(exit_code), 32'd0);
    check("r_cycles", cycles, 32'd0);
    check("r_out_count", 32'(out_count), 32'd0);
    check("r_stim_full", 32'(stim_full), 32'd0);
    res_q.push_back('{1'b0, 1'b1, 8'h00, 16'd0, 1'b1, 32'd100});
    reset = 1'b0;
    fork
      begin
        int k;
        k = 0;
        while (soc_reset && k < 20) begin
          k++;
          @(negedge clock);
        end
        check("soc_reset_len", 32'(k), 32'(RC));
      end
      begin
        for (int i = 0; i < 18; i++) begin
          stim_we   = 1'b1;
          stim_data = 8'h41 + 8'(i);
          if (i < 17) exp_q.push_back(stim_data);
          @(negedge clock);
          if (i == 15) check("full_early", 32'(stim_full), 32'd0);
          if (i == 16) check("full_set", 32'(stim_full), 32'd1);
        end
        stim_we = 1'b0;
      end
    join
    check("full_hold", 32'(stim_full), 32'd1);
    check("stall_valid", 32'(soc_in_valid), 32'd1);
    check("stall_data", 32'(soc_in_data), 32'h41);
    repeat (2) @(negedge clock);
    soc_in_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clock);
    check("in_idle", 32'(soc_in_valid), 32'd0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("tmo_done", 32'(done), 32'd1);
    repeat (5) @(negedge clock);
    check("cycles_frozen", cycles, 32'd100);
    check("tmo_sticky", 32'(timed_out), 32'd1);
    check("done_ready", 32'(soc_out_ready), 32'd0);

    // clean pass: "hi" then exit 0
    restart();
    res_q.push_back('{1'b1, 1'b0, 8'h00, 16'd4, 1'b0, 32'd0});
    send_out(8'h68);
    send_out(8'h69);
    send_out(8'h04);
    send_out(8'h00);
    check("pass_done", 32'(done), 32'd1);
    check("pass_flag", 32'(pass), 32'd1);

    // failing exit code 3
    restart();
    res_q.push_back('{1'b0, 1'b0, 8'h03, 16'd2, 1'b0, 32'd0});
    send_out(8'h04);
    send_out(8'h03);
    check("fail_done", 32'(done), 32'd1);
    repeat (3) @(negedge clock);
    check("fail_sticky", 32'(exit_code), 32'h03);

    // exit byte accepted on the timeout cycle wins
    restart();
    res_q.push_back('{1'b1, 1'b0, 8'h00, 16'd2, 1'b1, 32'd100});
    send_out(8'h04);
    n = 0;
    while (cycles != 32'd99 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("edge_reach", cycles, 32'd99);
    send_out(8'h00);
    check("edge_tmo", 32'(timed_out), 32'd0);
    check("edge_pass", 32'(pass), 32'd1);

    // reset mid-run flushes queued stimulus
    restart();
    soc_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stim_we   = 1'b1;
      stim_data = 8'h70 + 8'(i);
      @(negedge clock);
    end
    stim_we = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_valid", 32'(soc_in_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_soc_reset", 32'(soc_reset), 32'd1);
    check("mid_in_valid", 32'(soc_in_valid), 32'd0);
    check("mid_cycles", cycles, 32'd0);
    @(negedge clock);
    reset        = 1'b0;
    soc_in_ready = 1'b1;
    repeat (30) @(negedge clock);
    check("flushed", 32'(soc_in_valid), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("res_left", 32'(res_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
